pow2_serial: RTL and testbench

//   Inverse of the combinational log2 MSB-index encoder. Takes a bit index k and

---
 rtl/pow2_serial.sv | 95 +++++++++
 tb/tb_pow2_serial.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pow2_serial.sv
// Iterative 2^k / low-fill mask generator: one shift per clock, valid/ready on both sides.
// Rebuilds magnitudes and normalisation masks from a bit index.
module pow2_serial #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] k,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);

  localparam logic [IDX_W-1:0] K_MAX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] acc_reg, acc_next, acc_shifted;
  logic [IDX_W-1:0] cnt_reg, cnt_next, k_sat;
  logic             mode_reg, mode_next;

  // Compared as int so the range check stays well-formed when WIDTH is a power of two.
  always_comb begin
    k_sat = k;
    if (int'(k) > WIDTH - 1) begin
      k_sat = K_MAX;
    end
  end

  // Shift by one position; the vacated LSB takes the latched mode bit (0: power, 1: mask).
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (gi == 0) begin : g_lsb
        assign acc_shifted[gi] = mode_reg;
      end else begin : g_upper
        assign acc_shifted[gi] = acc_reg[gi-1];
      end
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    mode_next  = mode_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          mode_next  = mode;
          acc_next   = WIDTH'(1);
          cnt_next   = k_sat;
          state_next = (k_sat == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        acc_next = acc_shifted;
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == IDX_W'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      mode_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      mode_reg  <= mode_next;
    end
  end

  // Outputs are masked by rst so nothing leaks out while reset is held.
  assign in_ready  = (state_reg == IDLE) && !rst;
  assign out_valid = (state_reg == DONE) && !rst;
  assign result    = out_valid ? acc_reg : '0;

endmodule

// File: tb/tb_pow2_serial.sv
// Self-checking bench for pow2_serial: directed corner cases plus randomized requests
// checked against an arithmetic model and a log2/popcount decode of each result.
module tb_pow2_serial;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  k;
  logic        mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  pow2_serial #(.WIDTH(32), .IDX_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .k         (k),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain arithmetic on the index.
  function automatic logic [31:0] model(input int kk, input bit mm);
    logic [63:0] v;
    v = mm ? ((64'd1 << (kk + 1)) - 64'd1) : (64'd1 << kk);
    return v[31:0];
  endfunction

  // Downstream log2 encoder: index of the most significant set bit.
  function automatic int log2_msb(input logic [31:0] v);
    int idx;
    idx = -1;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

  task automatic run_req(input int kk, input bit mm, input int hold);
    int          guard;
    int          lat;
    logic [31:0] exp;
    exp   = model(kk, mm);
    guard = 0;
    while (!in_ready && guard < 100) begin
      step();
      guard++;
    end
    check("in_ready_wait", in_ready, 1'b1);
    in_valid  = 1'b1;
    k         = 5'(kk);
    mode      = mm;
    out_ready = 1'b0;
    step();
    // Inputs after acceptance must be ignored.
    in_valid = 1'b0;
    k        = 5'($urandom);
    mode     = 1'($urandom);
    lat      = 0;
    while (!out_valid && lat < 100) begin
      check("busy_in_ready", in_ready, 1'b0);
      in_valid = 1'($urandom);
      step();
      lat++;
    end
    in_valid = 1'b0;
    check("latency", lat, kk);
    check("result", result, exp);
    check("log2", log2_msb(result), kk);
    check("popcount", $countones(result), mm ? kk + 1 : 1);
    $display("req k=%0d mode=%0d result=%h lat_cycles=%0d hold=%0d", kk, mm, result, lat + 1, hold);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      step();
      check("hold_valid", out_valid, 1'b1);
      check("hold_result", result, exp);
      check("hold_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    check("drain_valid", out_valid, 1'b0);
    check("drain_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    k         = 5'd3;
    mode      = 1'b0;
    out_ready = 1'b0;
    #1;
    // T1: reset behaviour; a request offered during reset is not taken.
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_result", result, 32'h0);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1'b1);
    step();
    check("rst_req_dropped", in_ready, 1'b1);
    run_req(0, 1'b0, 0);
    run_req(0, 1'b1, 0);
    // T2, T3: mid-range and extreme indices.
    run_req(5, 1'b0, 0);
    run_req(5, 1'b1, 0);
    run_req(31, 1'b1, 0);
    run_req(31, 1'b0, 0);
    // T4: back-pressure with a blocked request during DONE.
    run_req(16, 1'b0, 3);

    // T5: reset in the middle of SHIFT.
    in_valid = 1'b1;
    k        = 5'd20;
    mode     = 1'b0;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("mid_busy", in_ready, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", in_ready, 1'b0);
    check("mid_rst_result", result, 32'h0);
    step();
    rst = 1'b0;
    #1;
    check("mid_post_in_ready", in_ready, 1'b1);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 30; i++) begin
        if (out_valid || result != 32'h0) seen++;
        step();
      end
      check("mid_no_out_valid", seen, 0);
    end
    $display("req k=20 mode=0 aborted by reset");

    // T6: randomized requests in both modes.
    for (int m = 0; m < 2; m++) begin
      for (int n = 0; n < 20; n++) begin
        run_req(int'($urandom_range(0, 31)), 1'(m), int'($urandom_range(0, 3)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
